// File: rtl/sev_seg_reader.sv
// sev_seg_reader
// Watches a multiplexed, active-low seven-segment display bus and recovers,
// for each digit, the hex nibble and decimal point being shown. Patterns that
// are not one of the 16 hex glyphs are flagged as errors; all-dark patterns
// are flagged as blank.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   seg_n       segment lines a..g on bits 0..6, active-low
//   dp_n        decimal point line, active-low
//   dig_n       per-digit enables, active-low, bit i selects digit i
//   hex_out     recovered nibbles, digit i at [4i+3:4i]
//   dp_out      recovered decimal points, 1 = lit
//   valid       digit holds a fresh, legal glyph
//   err         last commit to the digit was an illegal pattern
//   blank       last commit to the digit had all segments dark
//   upd         one-cycle pulse on every commit
//   upd_idx     digit index of the commit signalled by upd
module sev_seg_reader #(
  parameter int NUM_DIGITS  = 4,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic                    dp_n,
  input  logic [NUM_DIGITS-1:0]   dig_n,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    upd,
  output logic [IDX_W-1:0]        upd_idx
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  logic [6:0]            seg_s1, seg_s2;
  logic                  dp_s1, dp_s2;
  logic [NUM_DIGITS-1:0] dig_s1, dig_s2;

  logic [6:0]            lit;
  logic                  dpl;
  logic [NUM_DIGITS-1:0] en;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      lat_idx;
  logic [6:0]            lat_lit;
  logic                  lat_dpl;
  logic [TO_W-1:0]       to_cnt [NUM_DIGITS];

  logic                  one_hot;
  logic [IDX_W-1:0]      cur_idx;
  logic [3:0]            glyph_nib;
  logic                  glyph_ok;
  logic                  glyph_blank;
  logic                  same;
  logic                  do_latch;
  logic                  do_inc;
  logic [CNT_W-1:0]      cnt_next;
  logic                  commit;

  // Two-flop synchronizers; everything downstream sees only the *_s2 copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dp_s1  <= 1'b0;
      dp_s2  <= 1'b0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      dp_s1  <= dp_n;
      dp_s2  <= dp_s1;
      dig_s1 <= dig_n;
      dig_s2 <= dig_s1;
    end
  end

  assign lit = ~seg_s2;
  assign dpl = ~dp_s2;
  assign en  = ~dig_s2;

  // Glyph decode of the current lit pattern (bits g..a).
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_nib = 4'h0;
    case (lit)
      7'h3F: glyph_nib = 4'h0;
      7'h06: glyph_nib = 4'h1;
      7'h5B: glyph_nib = 4'h2;
      7'h4F: glyph_nib = 4'h3;
      7'h66: glyph_nib = 4'h4;
      7'h6D: glyph_nib = 4'h5;
      7'h7D: glyph_nib = 4'h6;
      7'h07: glyph_nib = 4'h7;
      7'h7F: glyph_nib = 4'h8;
      7'h67: glyph_nib = 4'h9;
      7'h77: glyph_nib = 4'hA;
      7'h7C: glyph_nib = 4'hB;
      7'h39: glyph_nib = 4'hC;
      7'h5E: glyph_nib = 4'hD;
      7'h79: glyph_nib = 4'hE;
      7'h71: glyph_nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
    glyph_blank = (lit == 7'h00);
  end

  // Active digit index and the latch/increment/commit decision. A commit
  // happens on the edge where the stability count would reach STABLE_CYC,
  // which with STABLE_CYC=1 is the latching edge itself.
  always_comb begin
    one_hot = $onehot(en);
    cur_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en[i]) cur_idx = IDX_W'(i);
    end
    same     = (cur_idx == lat_idx) && (lit == lat_lit) && (dpl == lat_dpl);
    do_latch = one_hot && ((state == IDLE) || !same);
    do_inc   = one_hot && (state == COUNT) && same;
    cnt_next = do_latch ? CNT_W'(1) : cnt + CNT_W'(1);
    commit   = (do_latch || do_inc) && (cnt_next == CNT_W'(STABLE_CYC));
  end

  // Stability FSM, per-digit result registers and timeout counters.
  // A commit to a digit takes priority over its timeout expiring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_idx <= '0;
      lat_lit <= '0;
      lat_dpl <= 1'b0;
      hex_out <= '0;
      dp_out  <= '0;
      valid   <= '0;
      err     <= '0;
      blank   <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) to_cnt[i] <= '0;
    end else begin
      if (!one_hot) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (do_latch) begin
        lat_idx <= cur_idx;
        lat_lit <= lit;
        lat_dpl <= dpl;
        cnt     <= cnt_next;
        state   <= commit ? HELD : COUNT;
      end else if (do_inc) begin
        cnt   <= cnt_next;
        state <= commit ? HELD : COUNT;
      end

      upd <= commit;
      if (commit) upd_idx <= cur_idx;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (commit && (cur_idx == IDX_W'(i))) begin
          to_cnt[i] <= '0;
          dp_out[i] <= dpl;
          if (glyph_ok) begin
            hex_out[4*i +: 4] <= glyph_nib;
            valid[i] <= 1'b1;
            err[i]   <= 1'b0;
            blank[i] <= 1'b0;
          end else if (glyph_blank) begin
            valid[i] <= 1'b0;
            err[i]   <= 1'b0;
            blank[i] <= 1'b1;
          end else begin
            valid[i] <= 1'b0;
            err[i]   <= 1'b1;
            blank[i] <= 1'b0;
          end
        end else begin
          if (to_cnt[i] != TO_W'(TIMEOUT_CYC)) to_cnt[i] <= to_cnt[i] + TO_W'(1);
          if (to_cnt[i] == TO_W'(TIMEOUT_CYC - 1)) valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sev_seg_reader.md
Name: sev_seg_reader

Overview:
- Receive-side counterpart of the hex-to-seven-segment decoder.
- Monitors a multiplexed, active-low seven-segment display bus (segment lines plus per-digit enables) and recovers the hex nibble and decimal point shown on each digit.
- Flags patterns that are not one of the 16 hex glyphs.
- Used as a self-check and loopback monitor next to the display driver, and as a bench scoreboard source.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, one enable bit each.
- STABLE_CYC, 4: consecutive identical synchronized samples required before a digit is committed (minimum 1).
- TIMEOUT_CYC, 1024: cycles without a commit to a digit before its valid flag is cleared (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  segment lines, active-low; bit0=a, bit1=b ... bit6=g
- dp_n  in  1  decimal point line, active-low
- dig_n  in  NUM_DIGITS  digit enables, active-low; bit i selects digit i
- hex_out  out  4*NUM_DIGITS  recovered nibble; digit i at bits [4i+3:4i]
- dp_out  out  NUM_DIGITS  recovered decimal point, 1 = lit
- valid  out  NUM_DIGITS  digit i holds a fresh, legal glyph
- err  out  NUM_DIGITS  last commit to digit i was an illegal pattern
- blank  out  NUM_DIGITS  last commit to digit i had all segments dark
- upd  out  1  one-cycle pulse on every commit
- upd_idx  out  clog2(NUM_DIGITS), minimum 1  digit index of the current commit; value is don't-care when upd=0

Behaviour:
- Reset: rst_n low asynchronously clears all outputs, synchronizers, counters and FSM state to 0/IDLE. Reset mid-count discards the pending sample.
- Input conditioning: seg_n, dp_n and dig_n each pass through a 2-flop synchronizer. All logic below uses the synchronized, inverted values: lit[6:0], dpl, en[].
- Glyph table (lit bits g..a, 1 = lit):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=67, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Every other non-zero value is illegal. The all-zero value is blank.
- FSM states: IDLE, COUNT, HELD.
  - IDLE: en not exactly one-hot (zero or multiple digits active). Counter held at 0. Entering COUNT latches {idx, lit, dpl} and sets cnt=1.
  - COUNT: if en is not one-hot, go to IDLE. If {idx, lit, dpl} differs from the latched value, re-latch and set cnt=1. Otherwise increment cnt. When cnt==STABLE_CYC the commit occurs on that edge and the FSM goes to HELD.
  - HELD: no further commits while the latched value persists. Any change goes to COUNT (re-latch, cnt=1). Loss of one-hot goes to IDLE.
  - With STABLE_CYC=1 the commit happens on the same edge as the latch; the FSM goes straight to HELD.
- Commit to digit i:
  - Always: upd=1, upd_idx=i, dp_out[i]=dpl, timeout counter i reset to 0.
  - Legal glyph: hex_out[i]=nibble, valid[i]=1, err[i]=0, blank[i]=0.
  - Illegal pattern: err[i]=1, valid[i]=0, blank[i]=0, hex_out[i] holds.
  - Blank: blank[i]=1, valid[i]=0, err[i]=0, hex_out[i] holds.
- Latency: pins changed before edge 0 and held give a commit with upd high after edge 2+STABLE_CYC-1; outputs update on that same edge.
- Timeout: per-digit counters saturate at TIMEOUT_CYC. On reaching TIMEOUT_CYC, valid[i] clears. hex_out, err, blank and dp hold. No upd pulse is generated.
- Simultaneous timeout expiry and commit on the same digit: the commit wins.
- Only one digit can be committed per cycle, so upd is never asserted for two digits at once.

Test Plan:
- Drive dig_n=1110, seg_n=~7D, dp_n=1 and hold. Required: upd pulse for exactly 1 cycle at edge 5 (STABLE_CYC=4), upd_idx=0, hex_out[3:0]=6, valid=0001, err=0.
- Scan digits 0..3 with glyphs 1, A, d, F, 16 cycles each. Required: hex_out=16'hFDA1, valid=1111, exactly 4 upd pulses per full scan.
- Apply a glitch: pattern changes after 2 stable cycles, then settles on 4F. Required: only one commit, with value 3; no commit for the glitch value.
- Drive illegal pattern lit=01 on digit 2, then blank (lit=00). Required: first err[2]=1 with valid[2]=0 and hex held; then blank[2]=1 and err[2]=0.
- Drive dig_n=1100 (two digits active) for 50 cycles. Required: no upd pulse. Next, stop scanning digit 1 for 1024 cycles. Required: valid[1] clears, hex_out[1] holds.
- Assert rst_n low mid-COUNT. Required: all outputs 0 immediately (asynchronous); after release, a full STABLE_CYC plus synchronizer latency is needed before the next commit.
